// File: rtl/draw_ground_layer_pkg.sv
// draw_ground_layer_pkg: display widths, tile geometry and the default colour key.
// Holds the timing/pixel bundle types that travel down the ground-layer pipeline.
package draw_ground_layer_pkg;

  localparam int HV_W      = 11;
  localparam int RGB_W     = 12;
  localparam int TILE_BITS = 7;
  localparam int TILE_SIZE = 128;

  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'h0F0;

  typedef struct packed {
    logic [HV_W-1:0]  hcount;
    logic [HV_W-1:0]  vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t vga;
    logic in_band;
  } gnd_t;

endpackage

// File: rtl/draw_ground_layer_delay.sv
// delay_line: WIDTH-bit shift register, CLK_DEL clocks deep, sync active-low reset.
// Ports: clk, rst_n, din[WIDTH], dout[WIDTH] (din delayed by CLK_DEL clocks).
module delay_line #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [CLK_DEL];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < CLK_DEL; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[CLK_DEL-1];

endmodule

// File: rtl/draw_ground_layer.sv
// draw_ground_layer: scrolling 128x128 ground tile band overlaid on the VGA stream.
// In: clk, rst_n, timing/rgb_in, scroll_en, rom_rgb. Out: rom_address, timing/rgb_out (+3 clk).
module draw_ground_layer
  import draw_ground_layer_pkg::*;
#(
  parameter int               GROUND_Y    = 472,
  parameter int               SCROLL_STEP = 2,
  parameter logic [RGB_W-1:0] KEY_COLOR   = KEY_COLOR_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [HV_W-1:0]         hcount_in,
  input  logic [HV_W-1:0]         vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    hblnk_in,
  input  logic                    vblnk_in,
  input  logic [RGB_W-1:0]        rgb_in,
  input  logic                    scroll_en,
  output logic [2*TILE_BITS-1:0]  rom_address,
  input  logic [RGB_W-1:0]        rom_rgb,
  output logic [HV_W-1:0]         hcount_out,
  output logic [HV_W-1:0]         vcount_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    hblnk_out,
  output logic                    vblnk_out,
  output logic [RGB_W-1:0]        rgb_out
);

  localparam logic [HV_W-1:0] Y_LO =
    HV_W'(GROUND_Y);
  localparam logic [HV_W-1:0] Y_HI =
    HV_W'(GROUND_Y + TILE_SIZE);
  localparam logic [TILE_BITS-1:0] STEP =
    TILE_BITS'(SCROLL_STEP);

  logic [TILE_BITS-1:0] scroll_off;
  logic                 vblnk_prev;
  logic                 band;
  logic [TILE_BITS-1:0] tx;
  logic [TILE_BITS-1:0] ty;
  gnd_t                 s_in;
  gnd_t                 s_d2;
  logic                 blank;
  logic                 show;

  assign band = (vcount_in >= Y_LO) &&
                (vcount_in < Y_HI) &&
                !hblnk_in && !vblnk_in;

  // 7-bit adds wrap the tile coordinates for free
  assign tx = hcount_in[TILE_BITS-1:0] + scroll_off;
  assign ty = TILE_BITS'(vcount_in - Y_LO);

  // Offset only moves on the vblank rising edge,
  // so a visible frame never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scroll_off <= '0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev && scroll_en)
        scroll_off <= scroll_off + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rom_address <= '0;
    else
      rom_address <= band ? {ty, tx} : '0;
  end

  always_comb begin
    s_in            = '0;
    s_in.vga.hcount = hcount_in;
    s_in.vga.vcount = vcount_in;
    s_in.vga.hsync  = hsync_in;
    s_in.vga.vsync  = vsync_in;
    s_in.vga.hblnk  = hblnk_in;
    s_in.vga.vblnk  = vblnk_in;
    s_in.vga.rgb    = rgb_in;
    s_in.in_band    = band;
  end

  // Stages 1 and 2: lines the bundle up with rom_rgb
  delay_line #(
    .WIDTH   ($bits(gnd_t)),
    .CLK_DEL (2)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (s_in),
    .dout  (s_d2)
  );

  assign blank = s_d2.vga.hblnk || s_d2.vga.vblnk;
  assign show  = s_d2.in_band && !blank &&
                 (rom_rgb != KEY_COLOR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s_d2.vga.hcount;
      vcount_out <= s_d2.vga.vcount;
      hsync_out  <= s_d2.vga.hsync;
      vsync_out  <= s_d2.vga.vsync;
      hblnk_out  <= s_d2.vga.hblnk;
      vblnk_out  <= s_d2.vga.vblnk;
      unique case (1'b1)
        blank:   rgb_out <= '0;
        show:    rgb_out <= rom_rgb;
        default: rgb_out <= s_d2.vga.rgb;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_ground_layer.sv
// tb_draw_ground_layer: random + directed stimulus against a frame-level model.
// Includes a registered ROM model feeding rom_rgb from rom_address.
module tb_draw_ground_layer;

  localparam int          GY   = 472;
  localparam int          STEP = 2;
  localparam logic [11:0] KEY  = 12'h0F0;
  localparam int          MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [10:0] vcount_in = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        scroll_en = 1'b0;
  logic [13:0] rom_address;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  draw_ground_layer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .hblnk_in    (hblnk_in),
    .vblnk_in    (vblnk_in),
    .rgb_in      (rgb_in),
    .scroll_en   (scroll_en),
    .rom_address (rom_address),
    .rom_rgb     (rom_rgb),
    .hcount_out  (hcount_out),
    .vcount_out  (vcount_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .hblnk_out   (hblnk_out),
    .vblnk_out   (vblnk_out),
    .rgb_out     (rgb_out)
  );

  always #5 clk = ~clk;

  logic [11:0] rom_mem [16384];

  always @(posedge clk) rom_rgb <= rom_mem[rom_address];

  typedef struct {
    logic        rst;
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    int          rgb;
    logic        band;
    int          addr;
  } rec_t;

  rec_t hist [MAXC];
  int   cyc = 0;
  int   nedge = 0;
  logic vb_prev = 1'b0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  task automatic check(string name, int got, int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  name, cyc, got, exp);
  endtask

  // Model: frame-level scroll count + per-pixel tile lookup
  initial begin
    rec_t r;
    rec_t e;
    int   off;
    int   tx;
    int   ty;
    bit   ok;
    int   eg;
    forever begin
      @(posedge clk);
      if (cyc < MAXC) begin
        r.rst = rst_n;
        r.h   = int'(hcount_in);
        r.v   = int'(vcount_in);
        r.hs  = hsync_in;
        r.vs  = vsync_in;
        r.hb  = hblnk_in;
        r.vb  = vblnk_in;
        r.rgb = int'(rgb_in);
        off   = (nedge * STEP) % 128;
        r.band = rst_n && r.v >= GY &&
                 r.v < GY + 128 && !r.hb && !r.vb;
        tx = (r.h % 128 + off) % 128;
        ty = (r.v - GY) % 128;
        r.addr = r.band ? ty * 128 + tx : 0;
        if (!rst_n) begin
          nedge   = 0;
          vb_prev = 1'b0;
        end else begin
          if (r.vb && !vb_prev && scroll_en) nedge++;
          vb_prev = r.vb;
        end
        hist[cyc] = r;
        #1;
        check("rom_address", int'(rom_address), r.addr);
        ok = 1'b1;
        for (int k = cyc - 2; k <= cyc; k++)
          if (k < 0 || !hist[k].rst) ok = 1'b0;
        if (ok) begin
          e = hist[cyc-2];
          if (e.hb || e.vb) eg = 0;
          else if (e.band && rom_mem[e.addr] != KEY)
            eg = int'(rom_mem[e.addr]);
          else eg = e.rgb;
          check("hcount_out", int'(hcount_out), e.h);
          check("vcount_out", int'(vcount_out), e.v);
          check("sync_blank",
                int'({hsync_out, vsync_out,
                      hblnk_out, vblnk_out}),
                int'({e.hs, e.vs, e.hb, e.vb}));
          check("rgb_out", int'(rgb_out), eg);
        end else begin
          check("rst_hcount", int'(hcount_out), 0);
          check("rst_vcount", int'(vcount_out), 0);
          check("rst_sync_blank",
                int'({hsync_out, vsync_out,
                      hblnk_out, vblnk_out}), 0);
          check("rst_rgb", int'(rgb_out), 0);
        end
        cyc++;
      end
    end
  end

  task automatic drive(int h, int v, bit hb, bit vb,
                       int rgb, bit se);
    @(negedge clk);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = 12'(rgb);
    scroll_en = se;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 100, 0, 0, 0, 0);
  endtask

  // Directed pixel with hand-computed address and colour
  task automatic pin(string nm, int h, int v, bit hb,
                     int rgb, int ea, int eg);
    drive(h, v, hb, 0, rgb, 0);
    tick();
    check({nm, "_addr"}, int'(rom_address), ea);
    idle();
    tick();
    idle();
    tick();
    check({nm, "_rgb"}, int'(rgb_out), eg);
    check({nm, "_hcnt"}, int'(hcount_out), h);
  endtask

  task automatic frame(bit se, int hi_len);
    for (int i = 0; i < hi_len; i++)
      drive(0, 100, 0, 1, 0, se);
    for (int i = 0; i < 4; i++)
      drive(0, 100, 0, 0, 0, se);
  endtask

  initial begin
    #80000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit vbs;
    for (int i = 0; i < 16384; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ?
                   KEY : 12'($urandom);
    rom_mem[14'h000A] = 12'hABC;
    rom_mem[14'h0085] = KEY;
    rom_mem[14'h3F8A] = 12'h9A5;
    rom_mem[14'h0081] = 12'hF00;
    rom_mem[14'h0083] = 12'h00F;
    rom_mem[14'h0001] = 12'h0AA;
    rom_mem[14'h0087] = 12'h5A5;

    for (int i = 0; i < 5; i++)
      drive(int'($urandom_range(0, 127)),
            GY + int'($urandom_range(0, 127)), 0,
            1'($urandom_range(0, 1)),
            int'($urandom), 1);
    tick();
    check("reset_addr", int'(rom_address), 0);
    check("reset_rgb", int'(rgb_out), 0);
    check("reset_hcnt", int'(hcount_out), 0);

    drive(10, GY, 0, 0, 'h555, 0);
    rst_n = 1'b1;
    tick();
    check("lat_addr", int'(rom_address), 'h000A);
    check("lat_rgb0", int'(rgb_out), 0);
    idle();
    tick();
    check("lat_rgb1", int'(rgb_out), 0);
    idle();
    tick();
    check("lat_rgb", int'(rgb_out), 'hABC);
    check("lat_hcnt", int'(hcount_out), 10);
    check("lat_vcnt", int'(vcount_out), GY);

    pin("key", 5, GY + 1, 0, 'h123, 'h0085, 'h123);
    pin("above", 10, GY - 1, 0, 'h456, 0, 'h456);
    pin("below", 10, GY + 128, 0, 'h789, 0, 'h789);
    pin("last_row", 10, GY + 127, 0, 'h333,
        'h3F8A, 'h9A5);
    pin("hblank", 20, GY + 8, 1, 'h777, 0, 0);

    for (int i = 0; i < 63; i++) frame(1, 4);
    pin("off126", 3, GY + 1, 0, 'h321, 'h0081, 'hF00);
    frame(1, 4);
    pin("off0", 3, GY + 1, 0, 'h321, 'h0083, 'h00F);
    for (int i = 0; i < 3; i++) frame(0, 4);
    pin("hold", 3, GY + 1, 0, 'h321, 'h0083, 'h00F);
    frame(1, 50);
    pin("long_vb", 3, GY + 1, 0, 'h246, 'h0085, 'h246);
    pin("tx_wrap", 127, GY, 0, 'h246, 'h0001, 'h0AA);

    drive(0, 100, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 100, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 100, 0, 0, 0, 0);
    pin("toggle", 3, GY + 1, 0, 'h246, 'h0087, 'h5A5);

    vbs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) vbs = !vbs;
      drive(int'($urandom_range(0, 1099)),
            int'($urandom_range(440, 639)),
            ($urandom_range(0, 7) == 0), vbs,
            int'($urandom),
            ($urandom_range(0, 3) != 0));
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
    end
    for (int i = 0; i < 4; i++) idle();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
